// File: rtl/arm_mem_arbiter_if.sv
// arm_mem_arbiter_if: requester handshakes and the shared memory port
// of arm_mem_arbiter, bundled with arbiter (slave) and client (master) views.
interface arm_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              gnt0;
   logic              done0;
   logic [DATA_W-1:0] rdata0;
   logic              excpt0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt1;
   logic              done1;
   logic [DATA_W-1:0] rdata1;
   logic              excpt1;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_we;
   logic              mem_excpt;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_excpt, mem_data_out,
      output gnt0, done0, rdata0, excpt0,
      output gnt1, done1, rdata1, excpt1,
      output mem_addr, mem_data_in, mem_we
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_excpt, mem_data_out,
      input  gnt0, done0, rdata0, excpt0,
      input  gnt1, done1, rdata1, excpt1,
      input  mem_addr, mem_data_in, mem_we
   );
endinterface

// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: two-requester round-robin arbiter for one arm_memory port.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 always win a tie.
module arm_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              reset,
   arm_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic              mem_we_q, mem_we_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              done0_q, done0_d;
   logic              done1_q, done1_d;
   logic              excpt0_q, excpt0_d;
   logic              excpt1_q, excpt1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              any_req;
   logic              arb_en;
   logic              win1;

   assign any_req = bus.req0 | bus.req1;

`ifdef ARB_FIXED_PRIORITY_EN
   assign win1 = bus.req1 & ~bus.req0;
`else
   logic last_q, last_d;
   assign win1 = bus.req1 & (~bus.req0 | ~last_q);
`endif

   // Outputs are registered: gnt shows while the bus registers load,
   // mem_we shows while the memory answers, done shows after capture.
   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      mem_we_d      = 1'b0;
      gnt0_d        = 1'b0;
      gnt1_d        = 1'b0;
      done0_d       = 1'b0;
      done1_d       = 1'b0;
      excpt0_d      = 1'b0;
      excpt1_d      = 1'b0;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
`ifndef ARB_FIXED_PRIORITY_EN
      last_d        = last_q;
`endif
      arb_en        = (state_q == IDLE) || (state_q == RESP);

      unique case (state_q)
         IDLE: ;
         ISSUE: begin
            mem_addr_d    = addr_q;
            mem_data_in_d = wdata_q;
            mem_we_d      = we_q;
            state_d       = RESP;
         end
         RESP: begin
            state_d = IDLE;
            if (owner_q) begin
               done1_d  = 1'b1;
               excpt1_d = bus.mem_excpt;
               if (!we_q) rdata1_d = bus.mem_data_out;
            end else begin
               done0_d  = 1'b1;
               excpt0_d = bus.mem_excpt;
               if (!we_q) rdata0_d = bus.mem_data_out;
            end
         end
         default: state_d = IDLE;
      endcase

      if (arb_en && any_req) begin
         owner_d = win1;
         gnt0_d  = ~win1;
         gnt1_d  = win1;
         we_d    = win1 ? bus.we1    : bus.we0;
         addr_d  = win1 ? bus.addr1  : bus.addr0;
         wdata_d = win1 ? bus.wdata1 : bus.wdata0;
         state_d = ISSUE;
`ifndef ARB_FIXED_PRIORITY_EN
         last_d  = win1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         owner_q       <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         mem_we_q      <= 1'b0;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         done0_q       <= 1'b0;
         done1_q       <= 1'b0;
         excpt0_q      <= 1'b0;
         excpt1_q      <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
         last_q        <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         mem_we_q      <= mem_we_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         done0_q       <= done0_d;
         done1_q       <= done1_d;
         excpt0_q      <= excpt0_d;
         excpt1_q      <= excpt1_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
`ifndef ARB_FIXED_PRIORITY_EN
         last_q        <= last_d;
`endif
      end
   end

   assign bus.gnt0        = gnt0_q;
   assign bus.gnt1        = gnt1_q;
   assign bus.done0       = done0_q;
   assign bus.done1       = done1_q;
   assign bus.excpt0      = excpt0_q;
   assign bus.excpt1      = excpt1_q;
   assign bus.rdata0      = rdata0_q;
   assign bus.rdata1      = rdata1_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.mem_we      = mem_we_q;
endmodule
